// File: rtl/md_pkg.sv
// Shared definitions for the multiply/divide unit: op codes, FSM states and
// the iteration-counter width helper.
package md_pkg;

    localparam logic [2:0] MD_MULT  = 3'd0;
    localparam logic [2:0] MD_MULTU = 3'd1;
    localparam logic [2:0] MD_DIV   = 3'd2;
    localparam logic [2:0] MD_DIVU  = 3'd3;
    localparam logic [2:0] MD_MTHI  = 3'd4;
    localparam logic [2:0] MD_MTLO  = 3'd5;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DIV  = 2'd2,
        DONE = 2'd3
    } md_state_t;

    // Counter wide enough to hold WIDTH itself, not just WIDTH-1.
    function automatic int md_cnt_w(input int width);
        return $clog2(width) + 1;
    endfunction

    localparam int MD_WIDTH = 32;
    localparam int CNT_W    = md_cnt_w(MD_WIDTH);

endpackage

// File: rtl/md_div_step.sv
// One restoring-division step: shift the next dividend bit into the partial
// remainder and subtract the divisor if it fits.
module md_div_step
    import md_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] rem_in,
    input  logic             dividend_bit,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] rem_out,
    output logic             q_bit
);

    logic [WIDTH:0] shifted;
    logic [WIDTH:0] diff;

    assign shifted = {rem_in, dividend_bit};
    assign diff    = shifted - {1'b0, divisor};
    assign q_bit   = (shifted >= {1'b0, divisor});
    assign rem_out = q_bit ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];

endmodule

// File: rtl/md_unit.sv
// Iterative multiply/divide unit with architectural HI/LO registers.
// Multiply is shift-add (MUL_STEP bits per cycle), divide is restoring
// (one bit per cycle); signed ops work on magnitudes and fix the sign at the end.
// Optional feature: define MD_DIV_ZERO_FLAG_EN to add the md_div_zero output.
module md_unit
    import md_pkg::*;
#(
    parameter int WIDTH    = 32,
    parameter int MUL_STEP = 1
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             E_md_start,
    input  logic [2:0]       E_md_control,
    input  logic             E_md_cancel,
    input  logic [WIDTH-1:0] E_A,
    input  logic [WIDTH-1:0] E_B,
    output logic             md_busy,
    output logic             md_signal,
    output logic [WIDTH-1:0] res_hi,
`ifdef MD_DIV_ZERO_FLAG_EN
    output logic             md_div_zero,
`endif
    output logic [WIDTH-1:0] res_lo
);

    localparam int CNT_BITS = md_cnt_w(WIDTH);
    localparam logic [CNT_BITS-1:0] MUL_LAST = CNT_BITS'(WIDTH / MUL_STEP - 1);
    localparam logic [CNT_BITS-1:0] DIV_LAST = CNT_BITS'(WIDTH - 1);

    md_state_t state;
    md_state_t state_next;

    logic load_mul;
    logic load_div;
    logic load_hi;
    logic load_lo;
    logic last_iter;

    logic [CNT_BITS-1:0] cnt;

    logic [2*WIDTH-1:0] acc;
    logic [2*WIDTH-1:0] mcand;
    logic [2*WIDTH-1:0] pp;
    logic [2*WIDTH-1:0] acc_next;
    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   mplier;
    logic               neg_prod;

    logic [WIDTH-1:0] divisor;
    logic [WIDTH-1:0] rem;
    logic [WIDTH-1:0] quo;
    logic [WIDTH-1:0] rem_next;
    logic [WIDTH-1:0] quo_next;
    logic [WIDTH-1:0] rem_fix;
    logic [WIDTH-1:0] quo_fix;
    logic [WIDTH-1:0] a_raw;
    logic             q_bit;
    logic             neg_quo;
    logic             neg_rem;
    logic             b_zero;

    logic             is_signed;
    logic             a_neg;
    logic             b_neg;
    logic [WIDTH-1:0] a_mag;
    logic [WIDTH-1:0] b_mag;

    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;
    logic             signal_q;

    // Operands are reduced to magnitudes at acceptance; sign flags are kept aside.
    assign is_signed = (E_md_control == MD_MULT) || (E_md_control == MD_DIV);
    assign a_neg     = is_signed & E_A[WIDTH-1];
    assign b_neg     = is_signed & E_B[WIDTH-1];
    assign a_mag     = a_neg ? -E_A : E_A;
    assign b_mag     = b_neg ? -E_B : E_B;

    // Partial product for the multiplier bits retired this cycle.
    always_comb begin
        pp = '0;
        for (int j = 0; j < MUL_STEP; j++) begin
            if (mplier[j]) begin
                pp = pp + (mcand << j);
            end
        end
    end

    assign acc_next = acc + pp;
    assign prod_fix = neg_prod ? -acc_next : acc_next;

    md_div_step #(
        .WIDTH(WIDTH)
    ) u_div_step (
        .rem_in      (rem),
        .dividend_bit(quo[WIDTH-1]),
        .divisor     (divisor),
        .rem_out     (rem_next),
        .q_bit       (q_bit)
    );

    assign quo_next = {quo[WIDTH-2:0], q_bit};
    assign quo_fix  = neg_quo ? -quo_next : quo_next;
    assign rem_fix  = neg_rem ? -rem_next : rem_next;

    // State register; reset may strike mid-operation.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state decode, busy output and the one-cycle load/finish strobes.
    always_comb begin
        state_next = state;
        md_busy    = 1'b0;
        load_mul   = 1'b0;
        load_div   = 1'b0;
        load_hi    = 1'b0;
        load_lo    = 1'b0;
        last_iter  = 1'b0;
        case (state)
            IDLE: begin
                if (E_md_start && !E_md_cancel) begin
                    case (E_md_control)
                        MD_MULT, MD_MULTU: begin
                            load_mul   = 1'b1;
                            state_next = MUL;
                        end
                        MD_DIV, MD_DIVU: begin
                            load_div   = 1'b1;
                            state_next = DIV;
                        end
                        MD_MTHI: load_hi = 1'b1;
                        MD_MTLO: load_lo = 1'b1;
                        default: ;
                    endcase
                end
            end
            MUL: begin
                md_busy = 1'b1;
                if (E_md_cancel) begin
                    state_next = IDLE;
                end else if (cnt == MUL_LAST) begin
                    last_iter  = 1'b1;
                    state_next = DONE;
                end
            end
            DIV: begin
                md_busy = 1'b1;
                if (E_md_cancel) begin
                    state_next = IDLE;
                end else if (cnt == DIV_LAST) begin
                    last_iter  = 1'b1;
                    state_next = DONE;
                end
            end
            DONE: state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Datapath: operand latch, iteration, and the HI/LO commit on the final step.
    // The commit uses the final iteration's result directly so HI/LO are already
    // valid while md_signal is high in DONE.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            cnt      <= '0;
            acc      <= '0;
            mcand    <= '0;
            mplier   <= '0;
            neg_prod <= 1'b0;
            divisor  <= '0;
            rem      <= '0;
            quo      <= '0;
            a_raw    <= '0;
            neg_quo  <= 1'b0;
            neg_rem  <= 1'b0;
            b_zero   <= 1'b0;
            hi       <= '0;
            lo       <= '0;
            signal_q <= 1'b0;
`ifdef MD_DIV_ZERO_FLAG_EN
            md_div_zero <= 1'b0;
`endif
        end else begin
            signal_q <= 1'b0;
`ifdef MD_DIV_ZERO_FLAG_EN
            md_div_zero <= 1'b0;
`endif
            if (load_mul) begin
                acc      <= '0;
                mcand    <= {{WIDTH{1'b0}}, a_mag};
                mplier   <= b_mag;
                neg_prod <= a_neg ^ b_neg;
                cnt      <= '0;
            end
            if (load_div) begin
                rem     <= '0;
                quo     <= a_mag;
                divisor <= b_mag;
                neg_quo <= a_neg ^ b_neg;
                neg_rem <= a_neg;
                a_raw   <= E_A;
                b_zero  <= (E_B == '0);
                cnt     <= '0;
            end
            if (load_hi) begin
                hi       <= E_A;
                signal_q <= 1'b1;
            end
            if (load_lo) begin
                lo       <= E_A;
                signal_q <= 1'b1;
            end
            if (state == MUL) begin
                acc    <= acc_next;
                mcand  <= mcand << MUL_STEP;
                mplier <= mplier >> MUL_STEP;
                cnt    <= cnt + 1'b1;
            end
            if (state == DIV) begin
                rem <= rem_next;
                quo <= quo_next;
                cnt <= cnt + 1'b1;
            end
            if (last_iter) begin
                signal_q <= 1'b1;
                if (state == DIV) begin
                    if (b_zero) begin
                        hi <= a_raw;
                        lo <= {WIDTH{1'b1}};
                    end else begin
                        hi <= rem_fix;
                        lo <= quo_fix;
                    end
`ifdef MD_DIV_ZERO_FLAG_EN
                    md_div_zero <= b_zero;
`endif
                end else begin
                    hi <= prod_fix[2*WIDTH-1:WIDTH];
                    lo <= prod_fix[WIDTH-1:0];
                end
            end
        end
    end

    assign md_signal = signal_q;
    assign res_hi    = hi;
    assign res_lo    = lo;

endmodule

// File: tb/tb_md_unit.sv
// Scoreboard bench for md_unit: directed ops push expected HI/LO/latency,
// a negedge monitor pops and compares on every md_signal pulse.
module tb_md_unit;

    logic        Clk;
    logic        Reset;
    logic        E_md_start;
    logic [2:0]  E_md_control;
    logic        E_md_cancel;
    logic [31:0] E_A;
    logic [31:0] E_B;
    logic        md_busy;
    logic        md_signal;
    logic [31:0] res_hi;
    logic [31:0] res_lo;
    logic        dz;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        logic        dz;
        int          issue;
        int          lat;
    } exp_t;

    exp_t sb[$];
    int   cyc    = 0;
    int   checks = 0;
    int   passes = 0;

    md_unit dut (
        .Clk         (Clk),
        .Reset       (Reset),
        .E_md_start  (E_md_start),
        .E_md_control(E_md_control),
        .E_md_cancel (E_md_cancel),
        .E_A         (E_A),
        .E_B         (E_B),
        .md_busy     (md_busy),
        .md_signal   (md_signal),
        .res_hi      (res_hi),
`ifdef MD_DIV_ZERO_FLAG_EN
        .md_div_zero (dz),
`endif
        .res_lo      (res_lo)
    );

`ifndef MD_DIV_ZERO_FLAG_EN
    assign dz = 1'b0;
`endif

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    always @(posedge Clk) cyc <= cyc + 1;

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
        end else begin
            passes++;
        end
    endtask

    // Monitor: every md_signal pulse must match the oldest expected result.
    always @(negedge Clk) begin
        if (Reset && md_signal) begin
            if (sb.size() == 0) begin
                checkOutput("unexpected_md_signal", 64'd1, 64'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                checkOutput("res_hi", {32'd0, res_hi}, {32'd0, e.hi});
                checkOutput("res_lo", {32'd0, res_lo}, {32'd0, e.lo});
                checkOutput("latency", 64'(cyc - e.issue + 1), 64'(e.lat));
`ifdef MD_DIV_ZERO_FLAG_EN
                checkOutput("md_div_zero", {63'd0, dz}, {63'd0, e.dz});
`endif
            end
        end
    end

    // Drive one request at a negedge; optionally push its expectation and drop start afterwards.
    task automatic applyStimulus(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                                 input logic [31:0] exp_hi, input logic [31:0] exp_lo,
                                 input logic exp_dz, input int lat, input bit push, input bit rel);
        exp_t e;
        @(negedge Clk);
        E_md_start   = 1'b1;
        E_md_control = op;
        E_A          = a;
        E_B          = b;
        if (push) begin
            e.hi    = exp_hi;
            e.lo    = exp_lo;
            e.dz    = exp_dz;
            e.issue = cyc + 1;
            e.lat   = lat;
            sb.push_back(e);
        end
        if (rel) begin
            @(negedge Clk);
            E_md_start = 1'b0;
            E_A        = 32'h5A5A_5A5A;
            E_B        = 32'hA5A5_A5A5;
        end
    endtask

    task automatic waitDrain(input int budget);
        int n = 0;
        while (sb.size() != 0 && n < budget) begin
            @(negedge Clk);
            n++;
        end
        checkOutput("drain", 64'(sb.size()), 64'd0);
        sb.delete();
        @(negedge Clk);
    endtask

    initial begin
        #300000;
        $display("[TB] FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int bad;
        Reset        = 1'b0;
        E_md_start   = 1'b0;
        E_md_control = 3'd0;
        E_md_cancel  = 1'b0;
        E_A          = '0;
        E_B          = '0;
        repeat (3) @(negedge Clk);
        checkOutput("reset_busy", {63'd0, md_busy}, 64'd0);
        checkOutput("reset_signal", {63'd0, md_signal}, 64'd0);
        checkOutput("reset_hi", {32'd0, res_hi}, 64'd0);
        checkOutput("reset_lo", {32'd0, res_lo}, 64'd0);
        Reset = 1'b1;

        // MTHI then MTLO back-to-back
        applyStimulus(MD_MTHI_C(), 32'hCAFE_BABE, 0, 32'hCAFE_BABE, 32'h0, 0, 1, 1, 0);
        applyStimulus(3'd5, 32'h1234_5678, 0, 32'hCAFE_BABE, 32'h1234_5678, 0, 1, 1, 1);
        waitDrain(10);

        // Reset pulled mid-DIV at cycle 10
        applyStimulus(3'd2, 32'd100, 32'd7, 0, 0, 0, 33, 0, 1);
        repeat (9) @(negedge Clk);
        Reset = 1'b0;
        #1;
        checkOutput("midop_reset_busy", {63'd0, md_busy}, 64'd0);
        checkOutput("midop_reset_hi", {32'd0, res_hi}, 64'd0);
        checkOutput("midop_reset_lo", {32'd0, res_lo}, 64'd0);
        repeat (2) @(negedge Clk);
        Reset = 1'b1;

        // IDLE accepts again after reset
        applyStimulus(3'd3, 32'd7, 32'd2, 32'd1, 32'd3, 0, 33, 1, 1);
        waitDrain(50);

        // MULT -3*7 with busy window check
        applyStimulus(3'd0, 32'hFFFF_FFFD, 32'd7, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 0, 33, 1, 1);
        bad = 0;
        if (md_busy !== 1'b1) bad++;
        for (int i = 2; i <= 32; i++) begin
            @(negedge Clk);
            if (md_busy !== 1'b1) bad++;
        end
        checkOutput("busy_cycles_1_32", 64'(bad), 64'd0);
        @(negedge Clk);
        checkOutput("busy_cycle_33", {63'd0, md_busy}, 64'd0);
        waitDrain(50);

        // Division and multiplication corner cases
        applyStimulus(3'd2, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 0, 33, 1, 1);
        waitDrain(50);
        applyStimulus(3'd2, 32'd100, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFF2, 0, 33, 1, 1);
        waitDrain(50);
        applyStimulus(3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 32'h8000_0000, 0, 33, 1, 1);
        waitDrain(50);
        applyStimulus(3'd3, 32'd1234, 32'd0, 32'd1234, 32'hFFFF_FFFF, 1, 33, 1, 1);
        waitDrain(50);
        applyStimulus(3'd2, 32'hFFFF_FFFB, 32'd0, 32'hFFFF_FFFB, 32'hFFFF_FFFF, 1, 33, 1, 1);
        waitDrain(50);
        applyStimulus(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 0, 33, 1, 1);
        waitDrain(50);
        applyStimulus(3'd0, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0, 0, 33, 1, 1);
        waitDrain(50);
        applyStimulus(3'd1, 32'h1234_5678, 32'h10, 32'h1, 32'h2345_6780, 0, 33, 1, 1);
        waitDrain(50);

        // Codes 6/7 do nothing
        for (int op = 6; op <= 7; op++) begin
            applyStimulus(3'(op), 32'hDEAD_0000, 32'd3, 0, 0, 0, 0, 0, 1);
            checkOutput("noop_busy", {63'd0, md_busy}, 64'd0);
            repeat (3) @(negedge Clk);
            checkOutput("noop_hi", {32'd0, res_hi}, 64'h1);
            checkOutput("noop_lo", {32'd0, res_lo}, 64'h2345_6780);
        end

        // Cancel arriving in DONE does not block the commit
        applyStimulus(3'd1, 32'd3, 32'd5, 32'd0, 32'd15, 0, 33, 1, 1);
        repeat (32) @(negedge Clk);
        E_md_cancel = 1'b1;
        @(negedge Clk);
        E_md_cancel = 1'b0;
        waitDrain(10);

        // Cancel mid-MULTU, with an ignored start while busy
        applyStimulus(3'd1, 32'd9, 32'd9, 0, 0, 0, 0, 0, 1);
        @(negedge Clk);
        E_md_start   = 1'b1;
        E_md_control = 3'd4;
        E_A          = 32'hDEAD_BEEF;
        @(negedge Clk);
        E_md_start = 1'b0;
        repeat (2) @(negedge Clk);
        E_md_cancel = 1'b1;
        @(negedge Clk);
        E_md_cancel = 1'b0;
        checkOutput("cancel_busy", {63'd0, md_busy}, 64'd0);
        repeat (40) @(negedge Clk);
        checkOutput("cancel_hi", {32'd0, res_hi}, 64'd0);
        checkOutput("cancel_lo", {32'd0, res_lo}, 64'd15);

        // Cancel and start together in IDLE: nothing accepted
        @(negedge Clk);
        E_md_start   = 1'b1;
        E_md_control = 3'd4;
        E_A          = 32'h1111_1111;
        E_md_cancel  = 1'b1;
        @(negedge Clk);
        E_md_control = 3'd0;
        E_B          = 32'd2;
        @(negedge Clk);
        checkOutput("cancel_start_busy", {63'd0, md_busy}, 64'd0);
        E_md_start  = 1'b0;
        E_md_cancel = 1'b0;
        repeat (3) @(negedge Clk);
        checkOutput("cancel_start_hi", {32'd0, res_hi}, 64'd0);

        checkOutput("scoreboard_empty", 64'(sb.size()), 64'd0);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

    function automatic logic [2:0] MD_MTHI_C();
        return 3'd4;
    endfunction

endmodule
